uart_word_tx: RTL



---
 rtl/dct_uart_pkg.sv | 17 +
 rtl/word_fifo.sv | 47 ++++
 rtl/uart_word_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dct_uart_pkg.sv
// Shared constants and FSM state type for the DCT-result UART word transmitter.
package dct_uart_pkg;

  localparam int   DATA_BITS      = 8;
  localparam int   BYTES_PER_WORD = 4;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with wrap-bit pointers; full is registered so the
// writer sees the status left by the previous edge.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_nxt, rd_nxt;
  logic             wr_en, rd_en;

  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign wr_nxt   = wr_en ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_nxt   = rd_en ? rd_ptr + (AW+1)'(1) : rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_word_tx.sv
// Buffers 32-bit words and sends each as four UART bytes, MSB byte first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 instead of 8N1).
module uart_word_tx
  import dct_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int              TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   BIT_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_e    state;
  logic [TW-1:0] timer;
  logic [2:0]   bit_idx;
  logic [1:0]   byte_idx;
  logic [31:0]  word_sr;
  logic [7:0]   cur_byte;
  logic         bit_end, tx_next;
  logic         fifo_full, fifo_empty, push, pop;
  logic [31:0]  fifo_data;

  assign push     = in_valid && !fifo_full;
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign in_ready = !fifo_full;
  assign bit_end  = (timer == BIT_LAST);
  assign cur_byte = word_sr[31:24];

  word_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    tx_next = 1'b1;
    case (state)
      ST_START:  tx_next = START_BIT;
      ST_DATA:   tx_next = cur_byte[bit_idx];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = ^cur_byte;
`endif
      ST_STOP:   tx_next = STOP_BIT;
      default:   tx_next = 1'b1;
    endcase
  end

  // The word register shifts left a byte per frame so the active byte is always the top one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word_sr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (pop) begin
            word_sr  <= fifo_data;
            byte_idx <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else timer <= timer + TW'(1);
        end
        ST_DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else bit_idx <= bit_idx + 3'd1;
          end else timer <= timer + TW'(1);
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            timer <= '0;
            state <= ST_STOP;
          end else timer <= timer + TW'(1);
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
              state <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              word_sr  <= {word_sr[23:0], 8'h00};
              state    <= ST_START;
            end
          end else timer <= timer + TW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx   <= tx_next;
      busy <= (state != ST_IDLE) || !fifo_empty;
      if (in_valid && fifo_full) overflow <= 1'b1;
    end
  end

endmodule
